// File: rtl/spi_ram_if.sv
// Command/response bus between the SPI slave front-end and the command RAM.
// The master drives 10-bit command words; the slave returns read bytes.
interface spi_ram_if;
   logic [9:0] din;
   logic       rx_valid;
   logic [7:0] dout;
   logic       tx_valid;

   modport master (
      output din,
      output rx_valid,
      input  dout,
      input  tx_valid
   );

   modport slave (
      input  din,
      input  rx_valid,
      output dout,
      output tx_valid
   );
endinterface

// File: rtl/spi_ram.sv
// Command-driven single-port RAM behind an SPI slave: address/data write and
// read commands arrive as 10-bit words, read data returns one cycle later.
module spi_ram #(
   parameter int MEM_DEPTH = 256,
   parameter int ADDR_SIZE = 8,
   parameter int AUTO_INC  = 1
) (
   input  logic       clk,
   input  logic       rst_n,
   spi_ram_if.slave   bus
);

   typedef enum logic [1:0] {
      CMD_WR_ADDR = 2'b00,
      CMD_WR_DATA = 2'b01,
      CMD_RD_ADDR = 2'b10,
      CMD_RD_DATA = 2'b11
   } cmd_e;

   localparam logic [ADDR_SIZE-1:0] PTR_STEP = (AUTO_INC != 0) ? ADDR_SIZE'(1) : '0;

   cmd_e                 cmd;
   logic [ADDR_SIZE-1:0] wr_ptr_q, wr_ptr_d;
   logic [ADDR_SIZE-1:0] rd_ptr_q, rd_ptr_d;
   logic [7:0]           dout_q, dout_d;
   logic                 tx_valid_q, tx_valid_d;
   logic                 mem_we;
   logic [7:0]           mem_q [MEM_DEPTH];

   assign cmd = cmd_e'(bus.din[9:8]);

   always_comb begin
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      dout_d     = dout_q;
      tx_valid_d = 1'b0;
      mem_we     = 1'b0;
      // rst_n gating keeps commands seen during reset out of the un-reset memory
      if (bus.rx_valid && rst_n) begin
         case (cmd)
            CMD_WR_ADDR: wr_ptr_d = bus.din[ADDR_SIZE-1:0];
            CMD_WR_DATA: begin
               mem_we   = 1'b1;
               wr_ptr_d = wr_ptr_q + PTR_STEP;
            end
            CMD_RD_ADDR: rd_ptr_d = bus.din[ADDR_SIZE-1:0];
            CMD_RD_DATA: begin
               dout_d     = mem_q[rd_ptr_q];
               tx_valid_d = 1'b1;
               rd_ptr_d   = rd_ptr_q + PTR_STEP;
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         dout_q     <= '0;
         tx_valid_q <= 1'b0;
      end else begin
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         dout_q     <= dout_d;
         tx_valid_q <= tx_valid_d;
      end
   end

   always_ff @(posedge clk) begin
      if (mem_we) mem_q[wr_ptr_q] <= bus.din[7:0];
   end

   assign bus.dout     = dout_q;
   assign bus.tx_valid = tx_valid_q;

endmodule

// File: tb/tb_spi_ram.sv
// Self-checking bench for spi_ram: a bench-side memory model feeds a queue of
// expected read bytes that each scenario pops when tx_valid appears.
module tb_spi_ram;

   logic clk;
   logic rst_n;
   int   checks;
   int   errors;

   logic [7:0] m_mem [256];
   logic [7:0] m_wr;
   logic [7:0] m_rd;
   logic [7:0] m_last;
   logic [7:0] exp_q [$];

   spi_ram_if bus ();

   spi_ram #(
      .MEM_DEPTH (256),
      .ADDR_SIZE (8),
      .AUTO_INC  (1)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   // Drive one command for one cycle and advance the model; returns #1 after the sampling edge.
   task automatic send(input logic [1:0] c, input logic [7:0] p);
      @(negedge clk);
      bus.din      = {c, p};
      bus.rx_valid = 1'b1;
      case (c)
         2'b00: m_wr = p;
         2'b01: begin m_mem[m_wr] = p; m_wr = m_wr + 8'd1; end
         2'b10: m_rd = p;
         default: begin exp_q.push_back(m_mem[m_rd]); m_rd = m_rd + 8'd1; end
      endcase
      @(posedge clk);
      #1;
      bus.rx_valid = 1'b0;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         bus.rx_valid = 1'b0;
         bus.din      = 10'($urandom);
         @(posedge clk);
         #1;
      end
   endtask

   task automatic test_reset;
      rst_n        = 1'b0;
      bus.rx_valid = 1'b0;
      bus.din      = '0;
      m_wr = '0; m_rd = '0; m_last = '0;
      repeat (3) @(posedge clk);
      #1;
      checks++; if (bus.tx_valid !== 1'b0) begin errors++; $display("FAIL reset_txv got %b exp 0", bus.tx_valid); end
      checks++; if (bus.dout !== 8'h00) begin errors++; $display("FAIL reset_dout got %h exp 00", bus.dout); end
      checks++; if (dut.wr_ptr_q !== 8'h00) begin errors++; $display("FAIL reset_wrptr got %h exp 00", dut.wr_ptr_q); end
      checks++; if (dut.rd_ptr_q !== 8'h00) begin errors++; $display("FAIL reset_rdptr got %h exp 00", dut.rd_ptr_q); end
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_basic;
      logic [7:0] e;
      send(2'b00, 8'h05);
      send(2'b01, 8'hA5);
      send(2'b10, 8'h05);
      checks++; if (bus.tx_valid !== 1'b0) begin errors++; $display("FAIL basic_addr_txv got %b exp 0", bus.tx_valid); end
      send(2'b11, 8'h00);
      e = exp_q.pop_front();
      checks++; if (bus.tx_valid !== 1'b1) begin errors++; $display("FAIL basic_txv got %b exp 1", bus.tx_valid); end
      checks++; if (bus.dout !== e) begin errors++; $display("FAIL basic_dout got %h exp %h", bus.dout, e); end
      m_last = e;
      idle(1);
      checks++; if (bus.tx_valid !== 1'b0) begin errors++; $display("FAIL basic_txv_drop got %b exp 0", bus.tx_valid); end
      checks++; if (bus.dout !== m_last) begin errors++; $display("FAIL basic_dout_hold got %h exp %h", bus.dout, m_last); end
   endtask

   task automatic test_back_to_back;
      logic [7:0] e;
      send(2'b00, 8'h10);
      send(2'b01, 8'h11);
      send(2'b01, 8'h22);
      send(2'b01, 8'h33);
      send(2'b10, 8'h10);
      for (int i = 0; i < 3; i++) begin
         send(2'b11, 8'h00);
         e = exp_q.pop_front();
         checks++; if (bus.tx_valid !== 1'b1) begin errors++; $display("FAIL b2b_txv[%0d] got %b exp 1", i, bus.tx_valid); end
         checks++; if (bus.dout !== e) begin errors++; $display("FAIL b2b_dout[%0d] got %h exp %h", i, bus.dout, e); end
         m_last = e;
      end
      idle(1);
      checks++; if (bus.tx_valid !== 1'b0) begin errors++; $display("FAIL b2b_txv_drop got %b exp 0", bus.tx_valid); end
   endtask

   task automatic test_wrap;
      logic [7:0] e;
      send(2'b00, 8'hFF);
      send(2'b01, 8'h7E);
      send(2'b01, 8'h81);
      checks++; if (dut.wr_ptr_q !== m_wr) begin errors++; $display("FAIL wrap_wrptr got %h exp %h", dut.wr_ptr_q, m_wr); end
      send(2'b10, 8'hFF);
      for (int i = 0; i < 2; i++) begin
         send(2'b11, 8'h00);
         e = exp_q.pop_front();
         checks++; if (bus.tx_valid !== 1'b1) begin errors++; $display("FAIL wrap_txv[%0d] got %b exp 1", i, bus.tx_valid); end
         checks++; if (bus.dout !== e) begin errors++; $display("FAIL wrap_dout[%0d] got %h exp %h", i, bus.dout, e); end
         m_last = e;
      end
      checks++; if (dut.rd_ptr_q !== m_rd) begin errors++; $display("FAIL wrap_rdptr got %h exp %h", dut.rd_ptr_q, m_rd); end
   endtask

   task automatic test_hazard;
      logic [7:0] e;
      send(2'b10, 8'h20);
      send(2'b00, 8'h20);
      send(2'b01, 8'h3C);
      send(2'b11, 8'h00);
      e = exp_q.pop_front();
      checks++; if (bus.tx_valid !== 1'b1) begin errors++; $display("FAIL hazard_txv got %b exp 1", bus.tx_valid); end
      checks++; if (bus.dout !== e) begin errors++; $display("FAIL hazard_dout got %h exp %h", bus.dout, e); end
      m_last = e;
   endtask

   task automatic test_idle;
      logic [7:0] e;
      for (int i = 0; i < 20; i++) begin
         idle(1);
         checks++; if (bus.tx_valid !== 1'b0) begin errors++; $display("FAIL idle_txv[%0d] got %b exp 0", i, bus.tx_valid); end
         checks++; if (bus.dout !== m_last) begin errors++; $display("FAIL idle_dout[%0d] got %h exp %h", i, bus.dout, m_last); end
      end
      checks++; if (dut.wr_ptr_q !== m_wr) begin errors++; $display("FAIL idle_wrptr got %h exp %h", dut.wr_ptr_q, m_wr); end
      checks++; if (dut.rd_ptr_q !== m_rd) begin errors++; $display("FAIL idle_rdptr got %h exp %h", dut.rd_ptr_q, m_rd); end
      send(2'b10, 8'h20);
      send(2'b11, 8'h00);
      e = exp_q.pop_front();
      checks++; if (bus.dout !== e) begin errors++; $display("FAIL idle_mem_keep got %h exp %h", bus.dout, e); end
      m_last = e;
   endtask

   task automatic test_random;
      logic [7:0] e;
      logic [7:0] a;
      send(2'b00, 8'h40);
      for (int i = 0; i < 32; i++) send(2'b01, 8'($urandom));
      for (int i = 0; i < 12; i++) begin
         a = 8'h40 + 8'($urandom_range(0, 31));
         send(2'b10, a);
         send(2'b11, 8'h00);
         e = exp_q.pop_front();
         checks++; if (bus.tx_valid !== 1'b1 || bus.dout !== e) begin
            errors++; $display("FAIL rand_read[%0d] addr %h got %b/%h exp 1/%h", i, a, bus.tx_valid, bus.dout, e);
         end
         m_last = e;
      end
   endtask

   task automatic test_reset_mid;
      logic [7:0] e;
      send(2'b10, 8'h05);
      send(2'b11, 8'h00);
      e = exp_q.pop_front();
      checks++; if (bus.tx_valid !== 1'b1) begin errors++; $display("FAIL rstmid_pre_txv got %b exp 1", bus.tx_valid); end
      #2;
      rst_n = 1'b0;
      #1;
      checks++; if (bus.tx_valid !== 1'b0) begin errors++; $display("FAIL rstmid_txv got %b exp 0", bus.tx_valid); end
      checks++; if (bus.dout !== 8'h00) begin errors++; $display("FAIL rstmid_dout got %h exp 00", bus.dout); end
      checks++; if (dut.wr_ptr_q !== 8'h00 || dut.rd_ptr_q !== 8'h00) begin
         errors++; $display("FAIL rstmid_ptrs got %h/%h exp 00/00", dut.wr_ptr_q, dut.rd_ptr_q);
      end
      // A write command presented during reset must not reach memory.
      @(negedge clk);
      bus.din      = {2'b01, 8'h55};
      bus.rx_valid = 1'b1;
      @(posedge clk);
      #1;
      checks++; if (dut.wr_ptr_q !== 8'h00) begin errors++; $display("FAIL rstmid_ignore_wrptr got %h exp 00", dut.wr_ptr_q); end
      @(negedge clk);
      bus.rx_valid = 1'b0;
      rst_n        = 1'b1;
      m_wr = '0; m_rd = '0; m_last = '0;
      send(2'b11, 8'h00);
      e = exp_q.pop_front();
      checks++; if (bus.tx_valid !== 1'b1 || bus.dout !== e) begin
         errors++; $display("FAIL rstmid_mem0 got %b/%h exp 1/%h", bus.tx_valid, bus.dout, e);
      end
      send(2'b10, 8'h05);
      send(2'b11, 8'h00);
      e = exp_q.pop_front();
      checks++; if (bus.tx_valid !== 1'b1 || bus.dout !== e) begin
         errors++; $display("FAIL rstmid_mem5 got %b/%h exp 1/%h", bus.tx_valid, bus.dout, e);
      end
   endtask

   initial begin
      checks = 0;
      errors = 0;
      test_reset();
      test_basic();
      test_back_to_back();
      test_wrap();
      test_hazard();
      test_idle();
      test_random();
      test_reset_mid();
      idle(2);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
